// File: rtl/ff_serial_feeder.sv
// Parallel-to-serial feeder for a clock-enabled flop: shifts a word out MSB-first on D with one CE strobe every DIV+1 cycles.
// Optional: define FF_SERIAL_FEEDER_PARITY_EN to append an even-parity bit as an extra strobe.
module ff_serial_feeder #(
    parameter int   WIDTH    = 8,
    parameter int   DIV_W    = 8,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic             CK,
    input  logic             SR_N,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    input  logic [WIDTH-1:0] LOAD_DATA,
    input  logic [DIV_W-1:0] DIV,
    output logic             D,
    output logic             CE,
    output logic             BUSY,
    output logic             DONE
);

`ifdef FF_SERIAL_FEEDER_PARITY_EN
    localparam int SH_W = WIDTH + 1;
`else
    localparam int SH_W = WIDTH;
`endif
    localparam int BW = $clog2(SH_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

`ifdef FF_SERIAL_FEEDER_PARITY_EN
    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        even_parity = ^w;
    endfunction

    function automatic logic [SH_W-1:0] load_word(input logic [WIDTH-1:0] w);
        load_word = {w, even_parity(w)};
    endfunction
`else
    function automatic logic [SH_W-1:0] load_word(input logic [WIDTH-1:0] w);
        load_word = w;
    endfunction
`endif

    state_t            state_r, state_s;
    logic [SH_W-1:0]   shreg_r, shreg_s;
    logic [DIV_W-1:0]  div_r, div_s;
    logic [DIV_W-1:0]  cnt_r, cnt_s;
    logic [BW-1:0]     bits_r, bits_s;
    logic              ready_r, ready_s;
    logic              d_r, d_s;
    logic              ce_r, ce_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              accept_s;

    assign accept_s = LOAD_VALID && ready_r && (state_r == ST_IDLE);

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_s = state_r;
        shreg_s = shreg_r;
        div_s   = div_r;
        cnt_s   = cnt_r;
        bits_s  = bits_r;
        ready_s = ready_r;
        d_s     = d_r;
        ce_s    = 1'b0;
        busy_s  = busy_r;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                d_s    = IDLE_VAL;
                busy_s = 1'b0;
                if (accept_s) begin
                    shreg_s = load_word(LOAD_DATA);
                    div_s   = DIV;
                    cnt_s   = DIV;
                    bits_s  = BW'(SH_W);
                    ready_s = 1'b0;
                    busy_s  = 1'b1;
                    state_s = ST_RUN;
                end else begin
                    ready_s = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt_r == {DIV_W{1'b0}}) begin
                    if (bits_r == {BW{1'b0}}) begin
                        // Last strobe was on the previous edge: DONE pulses now.
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end else begin
                        ce_s    = 1'b1;
                        d_s     = shreg_r[SH_W-1];
                        shreg_s = {shreg_r[SH_W-2:0], 1'b0};
                        bits_s  = bits_r - BW'(1);
                        if (bits_r == BW'(1)) begin
                            cnt_s = {DIV_W{1'b0}};
                        end else begin
                            cnt_s = div_r;
                        end
                    end
                end else begin
                    cnt_s = cnt_r - DIV_W'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                d_s     = IDLE_VAL;
                ready_s = 1'b1;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                d_s     = IDLE_VAL;
                ready_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge CK or negedge SR_N) begin
        if (!SR_N) begin
            state_r <= ST_IDLE;
            shreg_r <= {SH_W{1'b0}};
            div_r   <= {DIV_W{1'b0}};
            cnt_r   <= {DIV_W{1'b0}};
            bits_r  <= {BW{1'b0}};
            ready_r <= 1'b0;
            d_r     <= IDLE_VAL;
            ce_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            shreg_r <= shreg_s;
            div_r   <= div_s;
            cnt_r   <= cnt_s;
            bits_r  <= bits_s;
            ready_r <= ready_s;
            d_r     <= d_s;
            ce_r    <= ce_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign LOAD_READY = ready_r;
    assign D          = d_r;
    assign CE         = ce_r;
    assign BUSY       = busy_r;
    assign DONE       = done_r;

endmodule
